// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 8-bit RISC-V pipeline.
// EX/MEM latch -> branch resolve + data-memory access -> MEM/WB latch.
// Optional build macro MEM_STAGE_FAULT_EN: out-of-range accesses are
// suppressed and flagged on a sticky mem_fault. Without it addresses wrap
// modulo DMEM_DEPTH and mem_fault is tied low.
module mem_stage #(
   parameter int PC_SIZE    = 10,
   parameter int DMEM_DEPTH = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic [PC_SIZE-1:0] PC_jump,
   input  logic               zero,
   input  logic [7:0]         ALU_result,
   input  logic [7:0]         store_data,
   input  logic [4:0]         rd_in,
   input  logic               reg_write_in,
   input  logic               branch_in,
   input  logic               mem_read_in,
   input  logic               mem_to_reg_in,
   input  logic               mem_write_in,
   output logic               pc_src,
   output logic [PC_SIZE-1:0] PC_branch,
   output logic [7:0]         wb_data,
   output logic [4:0]         wb_rd,
   output logic               wb_reg_write,
   output logic               mem_fault
);

   localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

   typedef struct packed {
      logic [PC_SIZE-1:0] pc_jump;
      logic               zero;
      logic [7:0]         alu_result;
      logic [7:0]         store_data;
      logic [4:0]         rd;
      logic               reg_write;
      logic               branch;
      logic               mem_read;
      logic               mem_to_reg;
      logic               mem_write;
   } ex_mem_t;

   typedef struct packed {
      logic [7:0] data;
      logic [4:0] rd;
      logic       reg_write;
   } mem_wb_t;

   ex_mem_t    ex_d, ex_q;
   mem_wb_t    wb_d, wb_q;
   logic [7:0] dmem [DMEM_DEPTH];
   logic [AW-1:0] addr;
   logic       acc_ok;
   logic [7:0] rd_data;
   logic       do_store;
   logic       fault_q;

   // Next EX/MEM contents: flush turns the incoming slot into a bubble by
   // clearing only control bits; data fields still flow through.
   always_comb begin
      ex_d            = '0;
      ex_d.pc_jump    = PC_jump;
      ex_d.zero       = zero;
      ex_d.alu_result = ALU_result;
      ex_d.store_data = store_data;
      ex_d.rd         = rd_in;
      ex_d.reg_write  = reg_write_in  & ~flush;
      ex_d.branch     = branch_in     & ~flush;
      ex_d.mem_read   = mem_read_in   & ~flush;
      ex_d.mem_to_reg = mem_to_reg_in & ~flush;
      ex_d.mem_write  = mem_write_in  & ~flush;
   end

   // EX/MEM latch; stall holds it (and wins over flush).
   always_ff @(posedge clk) begin
      if (reset)       ex_q <= '0;
      else if (!stall) ex_q <= ex_d;
   end

   assign addr = ex_q.alu_result[AW-1:0];

`ifdef MEM_STAGE_FAULT_EN
   // Only addresses inside the array are legal; compare at 9 bits so a
   // 256-byte memory still works.
   always_comb acc_ok = ({1'b0, ex_q.alu_result} < 9'(DMEM_DEPTH));
`else
   // Upper address bits are ignored, so every access wraps into the array.
   always_comb acc_ok = 1'b1;
`endif

   // Combinational load; zero when no legal read is in flight.
   always_comb begin
      rd_data = 8'h00;
      if (ex_q.mem_read && acc_ok) rd_data = dmem[addr];
   end

   // Store commits at the edge that retires the slot; never under reset or
   // stall, so a held store is written exactly once.
   always_comb do_store = !reset && !stall && ex_q.mem_write && acc_ok;

   // Data memory; contents survive reset.
   always_ff @(posedge clk) begin
      if (do_store) dmem[addr] <= ex_q.store_data;
   end

   // Write-back selection for the MEM/WB latch.
   always_comb begin
      wb_d           = '0;
      wb_d.data      = ex_q.mem_to_reg ? rd_data : ex_q.alu_result;
      wb_d.rd        = ex_q.rd;
      wb_d.reg_write = ex_q.reg_write;
   end

   // MEM/WB latch.
   always_ff @(posedge clk) begin
      if (reset)       wb_q <= '0;
      else if (!stall) wb_q <= wb_d;
   end

`ifdef MEM_STAGE_FAULT_EN
   // Sticky fault: set when an illegal access retires, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset)
         fault_q <= 1'b0;
      else if (!stall && (ex_q.mem_read || ex_q.mem_write) && !acc_ok)
         fault_q <= 1'b1;
   end
`else
   // No fault tracking in the wrapping build.
   always_comb fault_q = 1'b0;
`endif

   assign pc_src       = ex_q.branch & ex_q.zero;
   assign PC_branch    = ex_q.pc_jump;
   assign wb_data      = wb_q.data;
   assign wb_rd        = wb_q.rd;
   assign wb_reg_write = wb_q.reg_write;
   assign mem_fault    = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage. Expected write-back bundles
// are pushed when an instruction is driven and popped at the edge that
// retires it into MEM/WB.
module tb_mem_stage;
   localparam int PC_SIZE = 10;
   localparam int DEPTH   = 64;

   logic               clk = 1'b0;
   logic               reset, stall, flush, zero;
   logic [PC_SIZE-1:0] PC_jump;
   logic [7:0]         ALU_result, store_data;
   logic [4:0]         rd_in;
   logic               reg_write_in, branch_in, mem_read_in, mem_to_reg_in, mem_write_in;
   logic               pc_src, wb_reg_write, mem_fault;
   logic [PC_SIZE-1:0] PC_branch;
   logic [7:0]         wb_data;
   logic [4:0]         wb_rd;

   mem_stage #(.PC_SIZE(PC_SIZE), .DMEM_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .PC_jump(PC_jump), .zero(zero), .ALU_result(ALU_result),
      .store_data(store_data), .rd_in(rd_in), .reg_write_in(reg_write_in),
      .branch_in(branch_in), .mem_read_in(mem_read_in),
      .mem_to_reg_in(mem_to_reg_in), .mem_write_in(mem_write_in),
      .pc_src(pc_src), .PC_branch(PC_branch), .wb_data(wb_data),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .mem_fault(mem_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic [4:0] rd;
      logic       rw;
   } wb_t;

   wb_t                exp_q[$];
   wb_t                last_wb;
   logic [7:0]         model [DEPTH];
   logic               exp_pc_src, nxt_pc_src, ex_bad, nxt_bad, exp_fault;
   logic [PC_SIZE-1:0] exp_pcb, nxt_pcb;
   int                 checks = 0;
   int                 errors = 0;

   // One clock edge; on a non-stalled edge the EX slot retires to MEM/WB.
   task automatic tick(input logic st);
      stall = st;
      @(posedge clk); #1;
      if (!st) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got 0 entries required >=1");
         end else begin
            last_wb = exp_q.pop_front();
         end
         if (ex_bad) exp_fault = 1'b1;
         exp_pc_src = nxt_pc_src;
         exp_pcb    = nxt_pcb;
         ex_bad     = nxt_bad;
      end
      checks++;
      if (wb_data !== last_wb.data) begin
         errors++; $display("FAIL wb_data got %h required %h", wb_data, last_wb.data);
      end
      checks++;
      if (wb_rd !== last_wb.rd) begin
         errors++; $display("FAIL wb_rd got %0d required %0d", wb_rd, last_wb.rd);
      end
      checks++;
      if (wb_reg_write !== last_wb.rw) begin
         errors++; $display("FAIL wb_reg_write got %b required %b", wb_reg_write, last_wb.rw);
      end
      checks++;
      if (pc_src !== exp_pc_src) begin
         errors++; $display("FAIL pc_src got %b required %b", pc_src, exp_pc_src);
      end
      checks++;
      if (PC_branch !== exp_pcb) begin
         errors++; $display("FAIL PC_branch got %h required %h", PC_branch, exp_pcb);
      end
      checks++;
      if (mem_fault !== exp_fault) begin
         errors++; $display("FAIL mem_fault got %b required %b", mem_fault, exp_fault);
      end
   endtask

   // Drive one instruction, predict its write-back, update the memory model.
   task automatic drive(input logic br, input logic z, input logic mr, input logic m2r,
                        input logic mw, input logic rw, input logic fl,
                        input logic [PC_SIZE-1:0] pcj, input logic [7:0] alu,
                        input logic [7:0] sd, input logic [4:0] rd);
      wb_t        e;
      logic       inr;
      logic [7:0] rdat;
      int         idx;
      PC_jump = pcj; zero = z; ALU_result = alu; store_data = sd; rd_in = rd;
      reg_write_in = rw; branch_in = br; mem_read_in = mr;
      mem_to_reg_in = m2r; mem_write_in = mw; flush = fl;
      if (fl) begin br = 0; mr = 0; m2r = 0; mw = 0; rw = 0; end
`ifdef MEM_STAGE_FAULT_EN
      inr = (int'(alu) < DEPTH);
`else
      inr = 1'b1;
`endif
      idx  = int'(alu) % DEPTH;
      rdat = (mr && inr) ? model[idx] : 8'h00;
      e.data = m2r ? rdat : alu;
      e.rd   = rd;
      e.rw   = rw;
      exp_q.push_back(e);
      if (mw && inr) model[idx] = sd;
      nxt_bad    = (mr || mw) && !inr;
      nxt_pc_src = br & z;
      nxt_pcb    = pcj;
      tick(1'b0);
   endtask

   task automatic bubble();
      drive(0, 0, 0, 0, 0, 0, 0, '0, 8'h00, 8'h00, 5'd0);
   endtask

   // Stalled cycle with junk (including a store and a flush) on the inputs.
   task automatic stall_cycle();
      PC_jump = PC_SIZE'($urandom); zero = 1'b1; ALU_result = 8'($urandom);
      store_data = 8'($urandom); rd_in = 5'($urandom); reg_write_in = 1'b1;
      branch_in = 1'b1; mem_read_in = 1'b1; mem_to_reg_in = 1'b1;
      mem_write_in = 1'b1; flush = 1'b1;
      tick(1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         PC_jump = PC_SIZE'($urandom); zero = 1'($urandom); ALU_result = 8'($urandom);
         store_data = 8'($urandom); rd_in = 5'($urandom); reg_write_in = 1'($urandom);
         branch_in = 1'($urandom); mem_read_in = 1'($urandom);
         mem_to_reg_in = 1'($urandom); mem_write_in = 1'($urandom);
         stall = 1'($urandom); flush = 1'($urandom);
         @(posedge clk); #1;
         checks++;
         if ({pc_src, PC_branch, wb_data, wb_rd, wb_reg_write, mem_fault} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got pc_src=%b PC_branch=%h wb_data=%h wb_rd=%0d wb_rw=%b fault=%b required all 0",
                     pc_src, PC_branch, wb_data, wb_rd, wb_reg_write, mem_fault);
         end
      end
      reset = 1'b0;
      #1;
      checks++;
      if (pc_src !== 1'b0) begin
         errors++; $display("FAIL post_reset_pc_src got %b required 0", pc_src);
      end
      exp_q.delete();
      exp_q.push_back('{data: 8'h00, rd: 5'd0, rw: 1'b0});
      last_wb = '{data: 8'h00, rd: 5'd0, rw: 1'b0};
      exp_pc_src = 1'b0; exp_pcb = '0; ex_bad = 1'b0; exp_fault = 1'b0;
   endtask

   task automatic test_preload();
      for (int i = 0; i < DEPTH; i++)
         drive(0, 0, 0, 0, 1, 0, 0, '0, 8'(i), 8'(i) ^ 8'h5A, 5'd0);
   endtask

   task automatic test_store_load();
      drive(0, 0, 0, 0, 1, 0, 0, '0, 8'h12, 8'hA5, 5'd0);
      bubble();
      drive(0, 0, 1, 1, 0, 1, 0, '0, 8'h12, 8'h00, 5'd5);
      bubble(); bubble();
   endtask

   task automatic test_branch();
      drive(1, 1, 0, 0, 0, 0, 0, 10'h155, 8'h00, 8'h00, 5'd0);
      drive(1, 0, 0, 0, 0, 0, 0, 10'h0AA, 8'h00, 8'h00, 5'd0);
      drive(1, 1, 0, 0, 0, 0, 1, 10'h2F0, 8'h00, 8'h00, 5'd0);
      bubble();
   endtask

   task automatic test_flush();
      drive(0, 0, 0, 0, 1, 1, 1, '0, 8'h08, 8'h3C, 5'd4);
      drive(0, 0, 1, 1, 0, 1, 0, '0, 8'h08, 8'h00, 5'd7);
      bubble(); bubble();
   endtask

   task automatic test_stall();
      drive(0, 0, 0, 0, 0, 1, 0, '0, 8'h41, 8'h00, 5'd2);
      drive(0, 0, 0, 0, 1, 0, 0, '0, 8'h20, 8'hC3, 5'd0);
      for (int i = 0; i < 3; i++) stall_cycle();
      drive(0, 0, 1, 1, 0, 1, 0, '0, 8'h20, 8'h00, 5'd9);
      drive(0, 0, 0, 0, 1, 0, 0, '0, 8'h21, 8'h4B, 5'd0);
      stall_cycle();
      drive(0, 0, 1, 1, 0, 1, 0, '0, 8'h21, 8'h00, 5'd10);
      bubble(); bubble();
   endtask

   task automatic test_back_to_back();
      drive(0, 0, 0, 0, 1, 0, 0, '0, 8'h30, 8'h6E, 5'd0);
      drive(0, 0, 1, 1, 0, 1, 0, '0, 8'h30, 8'h00, 5'd11);
      drive(0, 0, 1, 1, 1, 1, 0, '0, 8'h31, 8'hE1, 5'd12);
      drive(0, 0, 1, 1, 0, 1, 0, '0, 8'h31, 8'h00, 5'd13);
      bubble(); bubble();
   endtask

   task automatic test_fault();
      drive(0, 0, 0, 0, 1, 0, 0, '0, 8'h50, 8'h77, 5'd0);
      drive(0, 0, 1, 1, 0, 1, 0, '0, 8'h10, 8'h00, 5'd3);
      drive(0, 0, 1, 1, 0, 1, 0, '0, 8'h90, 8'h00, 5'd6);
      bubble(); bubble(); bubble();
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(4) == 0) stall_cycle();
         else begin
            case ($urandom_range(4))
               0: drive(0, 0, 1, 1, 0, 1, $urandom_range(5) == 0, '0, 8'($urandom), 8'h00, 5'($urandom));
               1: drive(0, 0, 0, 0, 1, 0, $urandom_range(5) == 0, '0, 8'($urandom), 8'($urandom), 5'd0);
               2: drive(0, 0, 0, 0, 0, 1, $urandom_range(5) == 0, '0, 8'($urandom), 8'h00, 5'($urandom));
               3: drive(1, 1'($urandom), 0, 0, 0, 0, $urandom_range(5) == 0, PC_SIZE'($urandom), 8'($urandom), 8'h00, 5'd0);
               default: drive(0, 0, 1, 1, 1, 1, 0, '0, 8'($urandom), 8'($urandom), 5'($urandom));
            endcase
         end
      end
      bubble(); bubble();
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      test_reset();
      test_preload();
      test_store_load();
      test_branch();
      test_flush();
      test_stall();
      test_back_to_back();
      test_fault();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
